quad_enc_emitter: RTL

//  Transmit side of the quadrature interface: turns step/dir pulses into A/B

---
 rtl/quad_enc_emitter.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/quad_enc_emitter.sv
// quad_enc_emitter: converts step/dir pulses into rate-limited A/B quadrature
// edges, buffering bursts in a signed pending accumulator.
// Ports: CLK, resetn (sync, active-low), enable, step, dir, config_edge_gap,
//        clear_overflow -> enc_a, enc_b, busy, overflow, emitted_count.
module quad_enc_emitter #(
    parameter int SYNC_STAGES  = 2,
    parameter int PENDING_BITS = 8,
    parameter int ENCBITS      = 32
) (
    input  logic                      CLK,
    input  logic                      resetn,
    input  logic                      enable,
    input  logic                      step,
    input  logic                      dir,
    input  logic [15:0]               config_edge_gap,
    input  logic                      clear_overflow,
    output logic                      enc_a,
    output logic                      enc_b,
    output logic                      busy,
    output logic                      overflow,
    output logic signed [ENCBITS-1:0] emitted_count
);

    localparam int PB = PENDING_BITS;
    localparam int PW = PENDING_BITS + 2;
    localparam logic signed [PW-1:0] LIM = PW'((1 << (PB - 1)) - 1);

    logic step_s;
    logic dir_s;

    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            assign step_s = step;
            assign dir_s  = dir;
        end else begin : g_sync
            logic [SYNC_STAGES-1:0] step_sync_q, step_sync_d;
            logic [SYNC_STAGES-1:0] dir_sync_q, dir_sync_d;

            always_comb begin
                step_sync_d    = step_sync_q;
                dir_sync_d     = dir_sync_q;
                step_sync_d[0] = step;
                dir_sync_d[0]  = dir;
                for (int i = 1; i < SYNC_STAGES; i++) begin
                    step_sync_d[i] = step_sync_q[i-1];
                    dir_sync_d[i]  = dir_sync_q[i-1];
                end
            end

            always_ff @(posedge CLK) begin
                if (!resetn) begin
                    step_sync_q <= '0;
                    dir_sync_q  <= '0;
                end else begin
                    step_sync_q <= step_sync_d;
                    dir_sync_q  <= dir_sync_d;
                end
            end

            assign step_s = step_sync_q[SYNC_STAGES-1];
            assign dir_s  = dir_sync_q[SYNC_STAGES-1];
        end
    endgenerate

    logic                      step_d_q;
    logic [1:0]                phase_q, phase_d;
    logic signed [PB-1:0]      pending_q, pending_d;
    logic [15:0]               gap_cnt_q, gap_cnt_d;
    logic signed [ENCBITS-1:0] count_q, count_d;
    logic                      overflow_q, overflow_d;
    logic                      busy_q, busy_d;

    logic [15:0]          gap;
    logic                 rise;
    logic                 gap_ok;
    logic                 emit;
    logic                 drop;
    logic signed [1:0]    delta_in;
    logic signed [1:0]    delta_out;
    logic signed [PW-1:0] sum;

    assign gap  = (config_edge_gap == 16'd0) ? 16'd1 : config_edge_gap;
    assign rise = step_s & ~step_d_q;

    // The emitting cycle counts as the first elapsed one, so edges land
    // exactly gap cycles apart (gap=1 gives an edge every cycle).
    assign gap_ok = ({1'b0, gap_cnt_q} + 17'd1) >= {1'b0, gap};
    assign emit   = enable && (pending_q != '0) && gap_ok;

    always_comb begin
        delta_in  = 2'sb00;
        delta_out = 2'sb00;
        if (rise && enable)
            delta_in = dir_s ? 2'sb01 : 2'sb11;
        if (emit)
            delta_out = pending_q[PB-1] ? 2'sb11 : 2'sb01;

        sum = $signed({{2{pending_q[PB-1]}}, pending_q})
            + $signed({{PB{delta_in[1]}}, delta_in})
            - $signed({{PB{delta_out[1]}}, delta_out});
        drop = (sum > LIM) || (sum < -LIM);

        phase_d = phase_q;
        if (emit) begin
            if (!pending_q[PB-1]) begin
                unique case (phase_q)
                    2'b00: phase_d = 2'b01;
                    2'b01: phase_d = 2'b11;
                    2'b11: phase_d = 2'b10;
                    2'b10: phase_d = 2'b00;
                endcase
            end else begin
                unique case (phase_q)
                    2'b00: phase_d = 2'b10;
                    2'b10: phase_d = 2'b11;
                    2'b11: phase_d = 2'b01;
                    2'b01: phase_d = 2'b00;
                endcase
            end
        end

        count_d = count_q + {{(ENCBITS-2){delta_out[1]}}, delta_out};

        // A step that would push past the limit is discarded; a
        // simultaneous emit still drains normally.
        if (!enable)
            pending_d = '0;
        else if (drop)
            pending_d = pending_q - {{(PB-2){delta_out[1]}}, delta_out};
        else
            pending_d = sum[PB-1:0];

        if (drop)
            overflow_d = 1'b1;
        else if (clear_overflow)
            overflow_d = 1'b0;
        else
            overflow_d = overflow_q;

        if (!enable)
            gap_cnt_d = gap;
        else if (emit)
            gap_cnt_d = 16'd0;
        else if (gap_cnt_q >= gap)
            gap_cnt_d = gap;
        else
            gap_cnt_d = gap_cnt_q + 16'd1;

        busy_d = (pending_d != '0);
    end

    always_ff @(posedge CLK) begin
        if (!resetn) begin
            step_d_q   <= 1'b0;
            phase_q    <= 2'b00;
            pending_q  <= '0;
            gap_cnt_q  <= gap;
            count_q    <= '0;
            overflow_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            step_d_q   <= step_s;
            phase_q    <= phase_d;
            pending_q  <= pending_d;
            gap_cnt_q  <= gap_cnt_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            busy_q     <= busy_d;
        end
    end

    assign enc_a         = phase_q[1];
    assign enc_b         = phase_q[0];
    assign busy          = busy_q;
    assign overflow      = overflow_q;
    assign emitted_count = count_q;

endmodule
